lwlw_report_collector: RTL and testbench

Downstream consumer of the lwlw automata stage: samples the 16 report lines (4 LTL properties × 4 report nodes) together with the pipelined symbol and automata-reset stream. It turns them into sticky per-property violation flags, saturating hit counters, an interrupt, and a timestamped event FIFO drained by a valid/ready consumer (CSR/trace unit). A small mode FSM gates capture and can freeze capture on the first violation.

---
 rtl/lwlw_monitor_pkg.sv | 33 +++
 rtl/lwlw_evt_fifo.sv | 69 ++++++
 rtl/lwlw_report_collector.sv | 149 ++++++++++++++
 tb/tb_lwlw_report_collector.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lwlw_monitor_pkg.sv
// Shared types and helpers for the lwlw report collector: property/report
// geometry, the collector mode enum and the event payload layout.
package lwlw_monitor_pkg;

    localparam int NUM_LTL         = 4;
    localparam int REPORTS_PER_LTL = 4;
    localparam int REPORT_W        = NUM_LTL * REPORTS_PER_LTL;
    localparam int SYMBOL_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MON  = 2'd1,
        ST_HALT = 2'd2
    } mon_state_e;

    // Symbol/report part of an event; the timestamp is prepended by the
    // top level because its width is a module parameter.
    typedef struct packed {
        logic [SYMBOL_W-1:0] symbol;
        logic [REPORT_W-1:0] report;
    } evt_payload_t;

    // One bit per property: set when any of that property's report nodes fired.
    function automatic logic [NUM_LTL-1:0] prop_hits(input logic [REPORT_W-1:0] report);
        logic [NUM_LTL-1:0] hits;
        hits = '0;
        for (int p = 0; p < NUM_LTL; p++) begin
            hits[p] = |report[p*REPORTS_PER_LTL +: REPORTS_PER_LTL];
        end
        return hits;
    endfunction

endpackage

// File: rtl/lwlw_evt_fifo.sv
// Generic synchronous FIFO with flush and occupancy output. Pointers carry
// one extra wrap bit so full and empty are distinguishable without a counter.
module lwlw_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 40,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             full_o,
    output logic [AW:0]      level_o
);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign valid_o = ~empty;
    assign level_o = wptr_q - rptr_q;
    assign data_o  = mem_q[rptr_q[AW-1:0]];

    // A pop frees the head slot this cycle, so a full FIFO may still accept a push.
    assign do_pop  = pop_i & ~empty & ~flush_i;
    assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

    // Pointer next-state: flush empties the FIFO by aligning read onto write.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            rptr_d = wptr_q;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Entry storage; cleared on reset so the head output reads zero afterwards.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/lwlw_report_collector.sv
// Collects lwlw automata report lines into sticky violation flags,
// saturating hit/drop counters, an interrupt and a timestamped event FIFO.
module lwlw_report_collector
    import lwlw_monitor_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TS_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       en_i,
    input  logic                       halt_on_viol_i,
    input  logic                       clear_i,
    input  logic [NUM_LTL-1:0]         irq_mask_i,
    input  logic                       run_i,
    input  logic                       automata_reset_i,
    input  logic [SYMBOL_W-1:0]        symbol_i,
    input  logic [REPORT_W-1:0]        report_i,
    output logic                       evt_valid_o,
    input  logic                       evt_ready_i,
    output logic [TS_W+SYMBOL_W+REPORT_W-1:0] evt_data_o,
    output logic [NUM_LTL-1:0]         viol_o,
    output logic                       irq_o,
    output logic [NUM_LTL*CNT_W-1:0]   hit_cnt_o,
    output logic [CNT_W-1:0]           ovf_cnt_o,
    output logic [1:0]                 state_o,
    output logic [$clog2(DEPTH):0]     fifo_level_o
);

    typedef struct packed {
        logic [TS_W-1:0] ts;
        evt_payload_t    payload;
    } evt_t;

    localparam int EVT_W = $bits(evt_t);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    mon_state_e                     state_q, state_d;
    logic [TS_W-1:0]                ts_q, ts_d;
    logic [NUM_LTL-1:0]             viol_q, viol_d;
    logic [NUM_LTL-1:0][CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]               ovf_cnt_q, ovf_cnt_d;

    logic                           hit;
    logic [NUM_LTL-1:0]             hit_props;
    logic                           fifo_full;
    logic                           pop;
    logic                           drop;
    evt_t                           evt_in;
    logic [EVT_W-1:0]               evt_out;

    // A hit only counts while monitoring on a live, non-reset symbol with no clear.
    assign hit_props = prop_hits(report_i);
    assign hit       = run_i & ~automata_reset_i & (state_q == ST_MON) & ~clear_i & (|report_i);
    assign pop       = evt_valid_o & evt_ready_i & ~clear_i;
    assign drop      = hit & fifo_full & ~pop;

    assign evt_in.ts             = ts_q;
    assign evt_in.payload.symbol = symbol_i;
    assign evt_in.payload.report = report_i;

    lwlw_evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (clear_i),
        .push_i  (hit),
        .pop_i   (pop),
        .data_i  (evt_in),
        .data_o  (evt_out),
        .valid_o (evt_valid_o),
        .full_o  (fifo_full),
        .level_o (fifo_level_o)
    );

    assign evt_data_o = evt_out;
    assign viol_o     = viol_q;
    assign irq_o      = |(viol_q & irq_mask_i);
    assign hit_cnt_o  = hit_cnt_q;
    assign ovf_cnt_o  = ovf_cnt_q;
    assign state_o    = state_q;

    // Mode FSM: disable wins, then clear re-arms monitoring, then normal progression.
    always_comb begin
        state_d = state_q;
        if (!en_i) begin
            state_d = ST_IDLE;
        end else if (clear_i) begin
            state_d = ST_MON;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_MON;
                ST_MON:  if (hit && halt_on_viol_i) state_d = ST_HALT;
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Trace timestamp: restarts on an automata reset, advances on every run cycle.
    always_comb begin
        ts_d = ts_q;
        if (run_i) begin
            ts_d = automata_reset_i ? '0 : ts_q + TS_W'(1);
        end
    end

    // Flags and counters: clear zeroes them, hits set/advance them.
    always_comb begin
        viol_d    = viol_q;
        hit_cnt_d = hit_cnt_q;
        ovf_cnt_d = ovf_cnt_q;
        if (clear_i) begin
            viol_d    = '0;
            hit_cnt_d = '0;
            ovf_cnt_d = '0;
        end else if (hit) begin
            viol_d = viol_q | hit_props;
            for (int p = 0; p < NUM_LTL; p++) begin
                if (hit_props[p]) hit_cnt_d[p] = sat_inc(hit_cnt_q[p]);
            end
            if (drop) ovf_cnt_d = sat_inc(ovf_cnt_q);
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            ts_q      <= '0;
            viol_q    <= '0;
            hit_cnt_q <= '0;
            ovf_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ts_q      <= ts_d;
            viol_q    <= viol_d;
            hit_cnt_q <= hit_cnt_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

endmodule

// File: tb/tb_lwlw_report_collector.sv
// Bench for lwlw_report_collector: directed scenarios followed by random
// traffic, all compared against a queue-based behavioural model.
module tb_lwlw_report_collector;

    localparam int DEPTH = 8;
    localparam int TS_W  = 16;
    localparam int CNT_W = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic                   clk = 1'b0;
    logic                   rst_ni = 1'b0;
    logic                   en_i = 1'b0;
    logic                   halt_on_viol_i = 1'b0;
    logic                   clear_i = 1'b0;
    logic [3:0]             irq_mask_i = 4'h0;
    logic                   run_i = 1'b0;
    logic                   automata_reset_i = 1'b0;
    logic [7:0]             symbol_i = 8'h00;
    logic [15:0]            report_i = 16'h0000;
    logic                   evt_ready_i = 1'b0;
    logic                   evt_valid_o;
    logic [TS_W+23:0]       evt_data_o;
    logic [3:0]             viol_o;
    logic                   irq_o;
    logic [4*CNT_W-1:0]     hit_cnt_o;
    logic [CNT_W-1:0]       ovf_cnt_o;
    logic [1:0]             state_o;
    logic [LW-1:0]          fifo_level_o;

    lwlw_report_collector #(.DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .en_i             (en_i),
        .halt_on_viol_i   (halt_on_viol_i),
        .clear_i          (clear_i),
        .irq_mask_i       (irq_mask_i),
        .run_i            (run_i),
        .automata_reset_i (automata_reset_i),
        .symbol_i         (symbol_i),
        .report_i         (report_i),
        .evt_valid_o      (evt_valid_o),
        .evt_ready_i      (evt_ready_i),
        .evt_data_o       (evt_data_o),
        .viol_o           (viol_o),
        .irq_o            (irq_o),
        .hit_cnt_o        (hit_cnt_o),
        .ovf_cnt_o        (ovf_cnt_o),
        .state_o          (state_o),
        .fifo_level_o     (fifo_level_o)
    );

    always #5 clk = ~clk;

    // Reference model state
    int                 m_st;
    int                 m_ts;
    logic [3:0]         m_viol;
    int                 m_hit [4];
    int                 m_ovf;
    logic [TS_W+23:0]   m_q [$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0;
        m_ts = 0;
        m_viol = 4'h0;
        for (int p = 0; p < 4; p++) m_hit[p] = 0;
        m_ovf = 0;
        m_q.delete();
    endtask

    // One clock edge of the collector's documented behaviour, from the inputs held at that edge.
    task automatic model_step();
        bit hit;
        bit pop;
        int cmax;
        cmax = (1 << CNT_W) - 1;
        hit = run_i && !automata_reset_i && (m_st == 1) && !clear_i && (report_i != 16'h0);
        pop = (m_q.size() > 0) && evt_ready_i;
        if (clear_i) begin
            m_q.delete();
            m_viol = 4'h0;
            for (int p = 0; p < 4; p++) m_hit[p] = 0;
            m_ovf = 0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (hit) begin
                for (int p = 0; p < 4; p++) begin
                    if (((report_i >> (4 * p)) & 16'hF) != 0) begin
                        m_viol[p] = 1'b1;
                        if (m_hit[p] < cmax) m_hit[p]++;
                    end
                end
                if (m_q.size() < DEPTH) begin
                    logic [15:0] tsv;
                    tsv = 16'(m_ts);
                    m_q.push_back({tsv, symbol_i, report_i});
                end else if (m_ovf < cmax) begin
                    m_ovf++;
                end
            end
        end
        if (!en_i)                         m_st = 0;
        else if (clear_i)                  m_st = 1;
        else if (m_st == 0)                m_st = 1;
        else if (m_st == 1 && hit && halt_on_viol_i) m_st = 2;
        if (run_i) m_ts = automata_reset_i ? 0 : ((m_ts + 1) % (1 << TS_W));
    endtask

    task automatic check_all();
        logic [4*CNT_W-1:0] ehit;
        for (int p = 0; p < 4; p++) ehit[p*CNT_W +: CNT_W] = CNT_W'(m_hit[p]);
        check("state", 64'(state_o), 64'(m_st));
        check("viol", 64'(viol_o), 64'(m_viol));
        check("irq", 64'(irq_o), 64'(|(m_viol & irq_mask_i)));
        check("hit_cnt", 64'(hit_cnt_o), 64'(ehit));
        check("ovf_cnt", 64'(ovf_cnt_o), 64'(m_ovf));
        check("level", 64'(fifo_level_o), 64'(m_q.size()));
        check("valid", 64'(evt_valid_o), 64'(m_q.size() > 0));
        if (m_q.size() > 0) check("data", 64'(evt_data_o), 64'(m_q[0]));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        model_reset();

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check_all();
        check("rst_data", 64'(evt_data_o), 64'd0);
        rst_ni = 1'b1;

        // First capture at ts=5
        en_i = 1'b1; run_i = 1'b1; automata_reset_i = 1'b1;
        cycle();
        automata_reset_i = 1'b0;
        repeat (5) cycle();
        report_i = 16'h0010; symbol_i = 8'hA3; irq_mask_i = 4'b0010;
        cycle();
        check("first_viol", 64'(viol_o), 64'(4'b0010));
        check("first_hit1", 64'(hit_cnt_o[CNT_W +: CNT_W]), 64'd1);
        check("first_data", 64'(evt_data_o), 64'({16'd5, 8'hA3, 16'h0010}));
        check("first_irq_on", 64'(irq_o), 64'd1);
        report_i = 16'h0000; irq_mask_i = 4'b1101;
        #1;
        check("first_irq_masked", 64'(irq_o), 64'd0);

        // Halt on first violation, then clear re-arms
        clear_i = 1'b1;
        cycle();
        clear_i = 1'b0; halt_on_viol_i = 1'b1; report_i = 16'h0001;
        cycle();
        cycle();
        check("halt_state", 64'(state_o), 64'd2);
        check("halt_level", 64'(fifo_level_o), 64'd1);
        report_i = 16'h0000; clear_i = 1'b1;
        cycle();
        clear_i = 1'b0; halt_on_viol_i = 1'b0;
        check("clear_state", 64'(state_o), 64'd1);
        check("clear_level", 64'(fifo_level_o), 64'd0);

        // Fill beyond depth, then pop+push on a full cycle
        evt_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            report_i = 16'(($urandom_range(1, 65535)));
            symbol_i = 8'($urandom);
            cycle();
        end
        check("full_level", 64'(fifo_level_o), 64'(DEPTH));
        check("full_ovf", 64'(ovf_cnt_o), 64'd2);
        evt_ready_i = 1'b1; report_i = 16'h0100;
        cycle();
        check("full_pp_level", 64'(fifo_level_o), 64'(DEPTH));
        check("full_pp_ovf", 64'(ovf_cnt_o), 64'd2);
        report_i = 16'h0000;
        repeat (DEPTH + 1) cycle();

        // Saturation of property 0 counter
        clear_i = 1'b1;
        cycle();
        clear_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            report_i = 16'(16'h0001 << $urandom_range(0, 3));
            cycle();
        end
        check("sat_hit0", 64'(hit_cnt_o[0 +: CNT_W]), 64'(4'hF));

        // Automata reset: hit ignored, timestamp restarts
        report_i = 16'h0000; clear_i = 1'b1;
        cycle();
        clear_i = 1'b0; evt_ready_i = 1'b0;
        automata_reset_i = 1'b1; report_i = 16'hFFFF;
        cycle();
        check("arst_level", 64'(fifo_level_o), 64'd0);
        automata_reset_i = 1'b0; report_i = 16'h1000; symbol_i = 8'h5A;
        cycle();
        check("arst_data", 64'(evt_data_o), 64'({16'd0, 8'h5A, 16'h1000}));

        // Asynchronous reset with FIFO at level 5
        clear_i = 1'b1; report_i = 16'h0000;
        cycle();
        clear_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            report_i = 16'(16'h0001 << $urandom_range(0, 15));
            cycle();
        end
        check("pre_rst_level", 64'(fifo_level_o), 64'd5);
        rst_ni = 1'b0;
        #1;
        model_reset();
        check_all();
        check("rst_mid_data", 64'(evt_data_o), 64'd0);
        @(posedge clk);
        #1;
        check_all();
        rst_ni = 1'b1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            en_i             = ($urandom_range(0, 15) != 0);
            clear_i          = ($urandom_range(0, 31) == 0);
            halt_on_viol_i   = ($urandom_range(0, 7) == 0);
            irq_mask_i       = 4'($urandom);
            run_i            = ($urandom_range(0, 3) != 0);
            automata_reset_i = ($urandom_range(0, 15) == 0);
            symbol_i         = 8'($urandom);
            report_i         = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom);
            evt_ready_i      = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
